set_bit_scanner: RTL and testbench

SET_BIT_SCANNER -- requirements
Module: set_bit_scanner

---
 rtl/set_bit_scanner_pkg.sv | 6 +
 rtl/set_bit_scanner_onehot_enc32.sv | 12 +
 rtl/set_bit_scanner.sv | 48 ++++
 tb/tb_set_bit_scanner.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/set_bit_scanner_pkg.sv
// set_bit_scanner_pkg: shared word/index widths and scanner FSM states
package set_bit_scanner_pkg;
  localparam int WIDTH = 32;
  localparam int IDXW = $clog2(WIDTH);
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SCAN = 1'b1} state_e;
endpackage

// File: rtl/set_bit_scanner_onehot_enc32.sv
// onehot_enc32: combinational 32-to-5 one-hot to binary encoder
module onehot_enc32
  import set_bit_scanner_pkg::*;
(
  input  logic [WIDTH-1:0] onehot_i,
  output logic [IDXW-1:0]  idx_o
);
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < WIDTH; i++) idx_o = idx_o | (onehot_i[i] ? IDXW'(i) : '0);
  end
endmodule

// File: rtl/set_bit_scanner.sv
// set_bit_scanner: emits the set bits of each accepted word, lowest index first
module set_bit_scanner
  import set_bit_scanner_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_onehot,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_last,
  output logic             out_zero
);
  state_e state_q, state_d;
  logic [WIDTH-1:0] residue_q, residue_d;
  logic zero_q, zero_d;
  logic accept, xfer;
  assign in_ready   = state_q == ST_IDLE;
  assign out_valid  = state_q == ST_SCAN;
  assign out_onehot = residue_q & (-residue_q);
  assign out_last   = (residue_q & (residue_q - 1'b1)) == '0;
  assign out_zero   = out_valid & zero_q;
  assign accept     = in_valid & in_ready;
  assign xfer       = out_valid & out_ready;
  onehot_enc32 u_enc (
    .onehot_i(out_onehot),
    .idx_o   (out_idx)
  );
  // the final beat wipes residue so an idle scanner always presents zeros
  always_comb begin
    residue_d = accept ? in_data : xfer ? (out_last ? '0 : residue_q & ~out_onehot) : residue_q;
    zero_d    = accept ? (in_data == '0) : (xfer && out_last) ? 1'b0 : zero_q;
    state_d   = accept ? ST_SCAN : (xfer && out_last) ? ST_IDLE : state_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      residue_q <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      residue_q <= residue_d;
      zero_q    <= zero_d;
    end
endmodule

// File: tb/tb_set_bit_scanner.sv
// tb_set_bit_scanner: directed scenario tests for set_bit_scanner
module tb_set_bit_scanner;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_onehot;
  logic [4:0]  out_idx;
  logic        out_last;
  logic        out_zero;
  int checks = 0;
  int fails = 0;

  set_bit_scanner dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_onehot(out_onehot), .out_idx(out_idx), .out_last(out_last), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_onehot !== 32'h0) begin fails++; $display("FAIL reset_onehot got %h want 0", out_onehot); end
    checks++; if (out_idx !== 5'd0) begin fails++; $display("FAIL reset_idx got %0d want 0", out_idx); end
    checks++; if (out_last !== 1'b1) begin fails++; $display("FAIL reset_last got %b want 1", out_last); end
    checks++; if (out_zero !== 1'b0) begin fails++; $display("FAIL reset_zero got %b want 0", out_zero); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_two_ends();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h8000_0001;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL ends_valid0 got %b want 1", out_valid); end
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL ends_ready0 got %b want 0", in_ready); end
    checks++; if (out_idx !== 5'd0 || out_last !== 1'b0) begin fails++; $display("FAIL ends_beat0 got idx %0d last %b want idx 0 last 0", out_idx, out_last); end
    step();
    checks++; if (out_idx !== 5'd31 || out_last !== 1'b1 || out_onehot !== 32'h8000_0000) begin fails++; $display("FAIL ends_beat1 got idx %0d last %b oh %h want idx 31 last 1 oh 80000000", out_idx, out_last, out_onehot); end
    step();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL ends_idle got ready %b valid %b want 1 0", in_ready, out_valid); end
  endtask

  task automatic test_zero();
    in_valid = 1'b1; in_data = 32'h0;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_onehot !== 32'h0 || out_idx !== 5'd0 || out_last !== 1'b1 || out_zero !== 1'b1)
      begin fails++; $display("FAIL zero_beat got v%b oh %h idx %0d last %b zero %b want v1 oh 0 idx 0 last 1 zero 1", out_valid, out_onehot, out_idx, out_last, out_zero); end
    step();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_zero !== 1'b0) begin fails++; $display("FAIL zero_idle got v%b r%b z%b want v0 r1 z0", out_valid, in_ready, out_zero); end
  endtask

  task automatic test_all_ones();
    logic [31:0] exp_oh;
    in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      exp_oh = 32'h1 << i;
      checks++; if (out_valid !== 1'b1 || out_idx !== 5'(i) || out_onehot !== exp_oh || out_last !== (i == 31) || out_zero !== 1'b0)
        begin fails++; $display("FAIL ones_beat%0d got v%b idx %0d oh %h last %b zero %b want v1 idx %0d oh %h last %b zero 0", i, out_valid, out_idx, out_onehot, out_last, out_zero, i, exp_oh, i == 31); end
      step();
    end
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL ones_idle got v%b r%b want v0 r1", out_valid, in_ready); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h0000_0A40;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) out_ready = 1'b1;
      checks++; if (out_valid !== 1'b1 || out_idx !== 5'd6 || out_onehot !== 32'h40 || out_last !== 1'b0)
        begin fails++; $display("FAIL bp_hold%0d got v%b idx %0d oh %h last %b want v1 idx 6 oh 40 last 0", c, out_valid, out_idx, out_onehot, out_last); end
      step();
    end
    checks++; if (out_idx !== 5'd9 || out_last !== 1'b0) begin fails++; $display("FAIL bp_beat9 got idx %0d last %b want 9 0", out_idx, out_last); end
    step();
    checks++; if (out_idx !== 5'd11 || out_last !== 1'b1) begin fails++; $display("FAIL bp_beat11 got idx %0d last %b want 11 1", out_idx, out_last); end
    step();
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_idle got %b want 1", in_ready); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h0000_F000;
    step();
    in_valid = 1'b0;
    checks++; if (out_idx !== 5'd12 || out_valid !== 1'b1) begin fails++; $display("FAIL rm_beat12 got idx %0d v%b want 12 1", out_idx, out_valid); end
    step();
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_onehot !== 32'h0) begin fails++; $display("FAIL rm_abort got v%b r%b oh %h want v0 r1 oh 0", out_valid, in_ready, out_onehot); end
    step();
    rst_n = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rm_quiet got v%b want 0", out_valid); end
    in_valid = 1'b1; in_data = 32'h4;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_idx !== 5'd2 || out_last !== 1'b1 || out_zero !== 1'b0)
      begin fails++; $display("FAIL rm_beat2 got v%b idx %0d last %b zero %b want v1 idx 2 last 1 zero 0", out_valid, out_idx, out_last, out_zero); end
    step();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL rm_idle got r%b v%b want r1 v0", in_ready, out_valid); end
  endtask

  task automatic test_ignore();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h3;
    step();
    in_data = 32'hFFFF_0000;
    checks++; if (out_idx !== 5'd0 || out_last !== 1'b0 || in_ready !== 1'b0) begin fails++; $display("FAIL ign_beat0 got idx %0d last %b r%b want 0 0 0", out_idx, out_last, in_ready); end
    step();
    in_data = 32'h100;
    checks++; if (out_idx !== 5'd1 || out_last !== 1'b1 || out_onehot !== 32'h2) begin fails++; $display("FAIL ign_beat1 got idx %0d last %b oh %h want 1 1 2", out_idx, out_last, out_onehot); end
    step();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL ign_idle got r%b v%b want r1 v0", in_ready, out_valid); end
    step();
    in_valid = 1'b0;
    checks++; if (out_idx !== 5'd8 || out_last !== 1'b1 || out_valid !== 1'b1) begin fails++; $display("FAIL ign_next got idx %0d last %b v%b want 8 1 1", out_idx, out_last, out_valid); end
    step();
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL ign_done got %b want 1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_two_ends();
    test_zero();
    test_all_ones();
    test_backpressure();
    test_reset_mid();
    test_ignore();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
